// File: rtl/text_console_pkg.sv
// -----------------------------------------------------------------------------
// text_console_pkg
// Shared definitions for the text console writer and the tile layer that reads
// the text buffer:
//   - state_e       : console controller states
//   - CHAR_*        : control codes the console interprets
//   - COL_BITS/ROW_BITS/ADDR_BITS : {row, col} text buffer address layout
//   - make_addr()   : packs a row/column pair into a text buffer address
// -----------------------------------------------------------------------------
package text_console_pkg;

    // Text buffer address layout: {row[4:0], col[4:0]}
    localparam int COL_BITS  = 5;
    localparam int ROW_BITS  = 5;
    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    // Control codes
    localparam logic [7:0] CHAR_BS        = 8'h08;
    localparam logic [7:0] CHAR_LF        = 8'h0A;
    localparam logic [7:0] CHAR_FF        = 8'h0C;
    localparam logic [7:0] CHAR_CR        = 8'h0D;
    localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_SCREEN = 2'd1,
        ST_CLR_LINE   = 2'd2
    } state_e;

    function automatic logic [ADDR_BITS-1:0] make_addr(
        input logic [ROW_BITS-1:0] row,
        input logic [COL_BITS-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/text_console_if.sv
// -----------------------------------------------------------------------------
// text_console_if
// Character stream in and text buffer write port out of the console.
//   i_char_valid / i_char / o_char_ready : upstream valid/ready character stream
//   o_wr_en / o_wr_addr / o_wr_data      : text buffer RAM write port
// Modports:
//   slave  : the console itself (consumes characters, drives the RAM port)
//   master : the upstream character source / RAM side
// -----------------------------------------------------------------------------
interface text_console_if;
    import text_console_pkg::*;

    logic                 i_char_valid;
    logic [7:0]           i_char;
    logic                 o_char_ready;
    logic                 o_wr_en;
    logic [ADDR_BITS-1:0] o_wr_addr;
    logic [7:0]           o_wr_data;

    modport slave (
        input  i_char_valid,
        input  i_char,
        output o_char_ready,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data
    );

    modport master (
        output i_char_valid,
        output i_char,
        input  o_char_ready,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data
    );

endinterface

// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
// Terminal-style writer for a COLS x ROWS character text buffer. Accepts one
// character code per handshake, interprets LF/CR/BS/FF, writes printable codes
// at the cursor and clears lines / the whole screen one cell per cycle.
// Ports:
//   i_pix_clk            : sole clock, rising edge
//   i_reset              : synchronous active-high reset
//   bus (slave)          : character stream in, text buffer write port out
//   o_cursor_col/row     : current cursor position
//   o_busy               : high while a line or screen clear is running
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module text_console
    import text_console_pkg::*;
#(
    parameter int unsigned COLS           = 32,
    parameter int unsigned ROWS           = 32,
    parameter logic [7:0]  BLANK_CHAR     = 8'h20,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                i_pix_clk,
    input  logic                i_reset,
    text_console_if.slave       bus,
    output logic [COL_BITS-1:0] o_cursor_col,
    output logic [ROW_BITS-1:0] o_cursor_row,
    output logic                o_busy
);

    localparam int                  COL_SHIFT   = $clog2(COLS);
    localparam logic [COL_BITS-1:0] COL_LAST    = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST    = ROW_BITS'(ROWS - 1);
    localparam logic [9:0]          COL_MASK    = 10'(COLS - 1);
    localparam logic [9:0]          LINE_LAST   = 10'(COLS - 1);
    localparam logic [9:0]          SCREEN_LAST = 10'(ROWS * COLS - 1);
    localparam state_e              RESET_STATE = CLEAR_ON_RESET ? ST_CLR_SCREEN : ST_IDLE;

    state_e               state_q, state_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [9:0]           clr_cnt_q, clr_cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 char_ready_q, char_ready_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic [ROW_BITS-1:0]  next_row;

    assign accept   = bus.i_char_valid && char_ready_q;
    // Rows wrap instead of scrolling
    assign next_row = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    // State register plus all registered outputs; reset aborts any clear in
    // progress and restarts from a known cursor and clear counter.
    always_ff @(posedge i_pix_clk) begin
        if (i_reset) begin
            state_q      <= RESET_STATE;
            col_q        <= '0;
            row_q        <= '0;
            clr_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            char_ready_q <= !CLEAR_ON_RESET;
            busy_q       <= CLEAR_ON_RESET;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: a wrapping printable or an LF starts a line clear of
    // the new row, FF starts a full-screen clear; clears end on their last cell.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.i_char >= CHAR_PRINT_MIN) begin
                        if (col_q == COL_LAST) begin
                            state_d = ST_CLR_LINE;
                        end
                    end else if (bus.i_char == CHAR_LF) begin
                        state_d = ST_CLR_LINE;
                    end else if (bus.i_char == CHAR_FF) begin
                        state_d = ST_CLR_SCREEN;
                    end
                end
            end
            ST_CLR_LINE: begin
                if (clr_cnt_q == LINE_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR_SCREEN: begin
                if (clr_cnt_q == SCREEN_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic: cursor movement, the single-cycle write strobe
    // and the clear counter, which sweeps the cells and wraps back to zero.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        clr_cnt_d    = clr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        char_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.i_char >= CHAR_PRINT_MIN) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = make_addr(row_q, col_q);
                        wr_data_d = bus.i_char;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = next_row;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else if (bus.i_char == CHAR_LF) begin
                        col_d = '0;
                        row_d = next_row;
                    end else if (bus.i_char == CHAR_CR) begin
                        col_d = '0;
                    end else if (bus.i_char == CHAR_BS) begin
                        if (col_q != '0) begin
                            col_d     = col_q - 1'b1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = make_addr(row_q, col_q - 1'b1);
                            wr_data_d = BLANK_CHAR;
                        end
                    end else if (bus.i_char == CHAR_FF) begin
                        col_d = '0;
                        row_d = '0;
                    end
                end
            end
            ST_CLR_LINE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = make_addr(row_q, COL_BITS'(clr_cnt_q));
                wr_data_d = BLANK_CHAR;
                clr_cnt_d = (clr_cnt_q == LINE_LAST) ? '0 : clr_cnt_q + 1'b1;
            end
            ST_CLR_SCREEN: begin
                // Linear counter split into row/column so narrower screens
                // still land on the {row, col} layout.
                wr_en_d   = 1'b1;
                wr_addr_d = make_addr(ROW_BITS'(clr_cnt_q >> COL_SHIFT),
                                      COL_BITS'(clr_cnt_q & COL_MASK));
                wr_data_d = BLANK_CHAR;
                clr_cnt_d = (clr_cnt_q == SCREEN_LAST) ? '0 : clr_cnt_q + 1'b1;
            end
            default: begin
                clr_cnt_d = '0;
            end
        endcase
    end

    assign bus.o_char_ready = char_ready_q;
    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_wr_data    = wr_data_q;
    assign o_cursor_col     = col_q;
    assign o_cursor_row     = row_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_text_console.sv
// -----------------------------------------------------------------------------
// tb_text_console
// Self-checking bench for text_console (32x32, blank 8'h20, clear on reset).
// Expected text buffer writes are pushed onto a queue as characters are sent
// and compared in order by a write monitor; cursor and status outputs are
// compared inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_text_console;
    import text_console_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int errors   = 0;
    int checks   = 0;
    int wr_count = 0;
    int m_col    = 0;
    int m_row    = 0;

    logic [17:0] exp_q[$];

    text_console_if bus ();

    text_console #(
        .COLS           (32),
        .ROWS           (32),
        .BLANK_CHAR     (8'h20),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .i_pix_clk    (clk),
        .i_reset      (rst),
        .bus          (bus.slave),
        .o_cursor_col (cursor_col),
        .o_cursor_row (cursor_row),
        .o_busy       (busy)
    );

    // 100 MHz pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest expected write
    initial begin
        logic [17:0] exp;
        forever begin
            @(negedge clk);
            if (bus.o_wr_en === 1'b1) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                             bus.o_wr_addr, bus.o_wr_data);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.o_wr_addr, bus.o_wr_data} !== exp) begin
                        errors++;
                        $display("[TB] FAIL write_%0d: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 wr_count, bus.o_wr_addr, bus.o_wr_data, exp[17:8], exp[7:0]);
                    end
                end
            end
        end
    end

    // Inputs change and outputs are sampled just after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_line(input int row);
        for (int c = 0; c < 32; c++) exp_q.push_back({5'(row), 5'(c), 8'h20});
    endtask

    task automatic push_screen();
        for (int a = 0; a < 1024; a++) exp_q.push_back({10'(a), 8'h20});
    endtask

    // Holds the code valid until accepted, updating the cursor model and the
    // expected writes just before the accepting edge.
    task automatic send_char(input logic [7:0] code);
        int waited = 0;
        bus.i_char_valid = 1'b1;
        bus.i_char       = code;
        while (bus.o_char_ready !== 1'b1 && waited < 3000) begin
            step();
            waited++;
        end
        if (bus.o_char_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: code %02h not accepted in %0d cycles, required acceptance",
                     code, waited);
            bus.i_char_valid = 1'b0;
            return;
        end
        if (code >= 8'h20) begin
            exp_q.push_back({5'(m_row), 5'(m_col), code});
            if (m_col == 31) begin
                m_col = 0;
                m_row = (m_row + 1) % 32;
                push_line(m_row);
            end else begin
                m_col++;
            end
        end else if (code == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 32;
            push_line(m_row);
        end else if (code == 8'h0D) begin
            m_col = 0;
        end else if (code == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back({5'(m_row), 5'(m_col), 8'h20});
            end
        end else if (code == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_screen();
        end
        step();
        bus.i_char_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            step();
            guard++;
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d expected writes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int busy_cycles = 0;
        rst = 1'b1;
        bus.i_char_valid = 1'b0;
        bus.i_char       = 8'h00;
        step();
        step();
        checks++;
        if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_wr: got en=%b addr=%0d data=%02h, required 0/0/00",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
        end
        checks++;
        if ({cursor_row, cursor_col} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_cursor: got (%0d,%0d), required (0,0)", cursor_col, cursor_row);
        end
        checks++;
        if ({busy, bus.o_char_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_status: got busy=%b ready=%b, required busy=1 ready=0",
                     busy, bus.o_char_ready);
        end
        push_screen();
        rst = 1'b0;
        while (busy === 1'b1 && busy_cycles < 2000) begin
            busy_cycles++;
            step();
        end
        checks++;
        if (busy_cycles != 1024) begin
            errors++;
            $display("[TB] FAIL reset_busy_cycles: got %0d, required 1024", busy_cycles);
        end
        checks++;
        if (bus.o_char_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready_after_clear: got %b, required 1", bus.o_char_ready);
        end
        drain("reset");
    endtask

    task automatic test_single_char();
        send_char(8'h41);
        checks++;
        if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 10'd0, 8'h41}) begin
            errors++;
            $display("[TB] FAIL single_write: got en=%b addr=%0d data=%02h, required 1/0/41",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
        end
        checks++;
        if (cursor_col !== 5'd1 || cursor_row !== 5'd0) begin
            errors++;
            $display("[TB] FAIL single_cursor: got (%0d,%0d), required (1,0)", cursor_col, cursor_row);
        end
        step();
        checks++;
        if (bus.o_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_strobe_width: got wr_en=%b, required 0", bus.o_wr_en);
        end
        drain("single");
    endtask

    task automatic test_line_wrap();
        send_char(8'h0C);
        drain("wrap_home");
        for (int i = 0; i < 32; i++) send_char(8'(8'hE0 + i));
        checks++;
        if (busy !== 1'b1 || cursor_col !== 5'd0 || cursor_row !== 5'd1) begin
            errors++;
            $display("[TB] FAIL wrap_line_clear: got busy=%b cursor (%0d,%0d), required busy=1 (0,1)",
                     busy, cursor_col, cursor_row);
        end
        send_char(8'h20);
        checks++;
        if (cursor_col !== 5'd1 || cursor_row !== 5'd1) begin
            errors++;
            $display("[TB] FAIL wrap_cursor: got (%0d,%0d), required (1,1)", cursor_col, cursor_row);
        end
        drain("wrap");
    endtask

    task automatic test_control();
        send_char(8'h58);
        send_char(8'h08);
        checks++;
        if (cursor_col !== 5'd1 || cursor_row !== 5'd1) begin
            errors++;
            $display("[TB] FAIL bs_cursor: got (%0d,%0d), required (1,1)", cursor_col, cursor_row);
        end
        send_char(8'h0D);
        checks++;
        if (cursor_col !== 5'd0 || cursor_row !== 5'd1 || bus.o_char_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cr_cursor: got (%0d,%0d) ready=%b, required (0,1) ready=1",
                     cursor_col, cursor_row, bus.o_char_ready);
        end
        send_char(8'h5A);
        send_char(8'h01);
        checks++;
        if (cursor_col !== 5'd1 || cursor_row !== 5'd1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignored_code: got (%0d,%0d) busy=%b, required (1,1) busy=0",
                     cursor_col, cursor_row, busy);
        end
        send_char(8'h0D);
        step();
        step();
        drain("control");
    endtask

    task automatic test_row_wrap();
        for (int i = 0; i < 30; i++) send_char(8'h0A);
        drain("row_walk");
        checks++;
        if (cursor_col !== 5'd0 || cursor_row !== 5'd31) begin
            errors++;
            $display("[TB] FAIL row_last: got (%0d,%0d), required (0,31)", cursor_col, cursor_row);
        end
        send_char(8'h0A);
        checks++;
        if (cursor_col !== 5'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("[TB] FAIL row_wrap: got (%0d,%0d), required (0,0)", cursor_col, cursor_row);
        end
        drain("row_wrap");
        send_char(8'h08);
        step();
        step();
        checks++;
        if (cursor_col !== 5'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("[TB] FAIL bs_col0: got (%0d,%0d), required (0,0)", cursor_col, cursor_row);
        end
        drain("bs_col0");
    endtask

    task automatic test_back_to_back();
        send_char(8'h4B);
        send_char(8'h0C);
        checks++;
        if (busy !== 1'b1 || bus.o_char_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ff_holdoff: got busy=%b ready=%b, required busy=1 ready=0",
                     busy, bus.o_char_ready);
        end
        send_char(8'h42);
        checks++;
        if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data} !== {1'b1, 10'd0, 8'h42} || cursor_col !== 5'd1) begin
            errors++;
            $display("[TB] FAIL held_char: got en=%b addr=%0d data=%02h col=%0d, required 1/0/42 col=1",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, cursor_col);
        end
        drain("back_to_back");
    endtask

    task automatic test_reset_mid_clear();
        int base;
        int guard = 0;
        send_char(8'h0C);
        base = wr_count;
        while (wr_count - base < 501 && guard < 2000) begin
            step();
            guard++;
        end
        rst = 1'b1;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        step();
        checks++;
        if (bus.o_wr_en !== 1'b0 || busy !== 1'b1 || {cursor_row, cursor_col} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL mid_clear_reset: got wr_en=%b busy=%b cursor (%0d,%0d), required 0/1 (0,0)",
                     bus.o_wr_en, busy, cursor_col, cursor_row);
        end
        push_screen();
        rst = 1'b0;
        drain("mid_clear");
        checks++;
        if ({cursor_row, cursor_col} !== 10'd0 || bus.o_char_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_clear_end: got cursor (%0d,%0d) ready=%b, required (0,0) ready=1",
                     cursor_col, cursor_row, bus.o_char_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_line_wrap();
        test_control();
        test_row_wrap();
        test_back_to_back();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
